// File: rtl/dataset_load_ctrl_if.sv
// Bus bundle for dataset_load_ctrl: deserializer record channel, dataset RAM
// port and compute-engine read channel.
//
// Handshake semantics:
//   rec_valid/rec_ready : a record transfers on a rising edge where both are
//                         high. rec_ready is combinational and high only
//                         while the controller is loading.
//   rd_req/rd_valid     : fire-and-forget requests. Every rd_req accepted in
//                         the serve phase yields exactly one rd_valid on the
//                         following cycle. Out-of-range addresses return zero.
//   ram_we/ram_re       : never high together. ram_rdata is expected one
//                         cycle after ram_re.
//
// Modports:
//   slave  : the controller side
//   master : the environment (deserializer, RAM, compute engine)
interface dataset_load_ctrl_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 256
);
  logic                  rec_valid;
  logic                  rec_ready;
  logic [DATA_WIDTH-1:0] rec_data;
  logic                  ram_we;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  modport slave (
    input  rec_valid, rec_data, ram_rdata, rd_req, rd_addr,
    output rec_ready, ram_we, ram_re, ram_addr, ram_wdata, rd_valid, rd_data
  );

  modport master (
    output rec_valid, rec_data, ram_rdata, rd_req, rd_addr,
    input  rec_ready, ram_we, ram_re, ram_addr, ram_wdata, rd_valid, rd_data
  );
endinterface

// File: rtl/dataset_load_ctrl.sv
// dataset_load_ctrl: sequences the dataset RAM through a load phase (records
// from the deserializer are masked and written to consecutive addresses) and
// a serve phase (the compute engine has exclusive single-cycle reads while
// epochs are counted).
//
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   start         pulse, begins a new load (ignored while busy)
//   num_dp        records to load
//   feat          feature count minus one; feat+1 fields plus nothing else kept
//   epochs        epochs to serve (0 treated as 1)
//   epoch_done    end-of-epoch pulse from the compute engine
//   epoch_cnt     epochs completed (saturating)
//   load_cnt      records written
//   busy / done   phase status
//   err_overrun   sticky: record strobe seen outside the load phase
//   err_range     sticky: read request beyond the loaded records
//   dbg_state     current FSM state encoding
//   bus           record / RAM / read channels (slave modport)
module dataset_load_ctrl #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15,
  parameter int LENGTH       = 16,
  parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] num_dp,
  input  logic [3:0]            feat,
  input  logic [7:0]            epochs,
  input  logic                  epoch_done,
  output logic [7:0]            epoch_cnt,
  output logic [ADDR_WIDTH-1:0] load_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  err_overrun,
  output logic                  err_range,
  output logic [2:0]            dbg_state,
  dataset_load_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_SERVE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] num_dp_q;
  logic [3:0]            feat_q;
  logic [7:0]            epochs_q;     // already max(epochs,1)
  logic [ADDR_WIDTH-1:0] load_cnt_q;
  logic [7:0]            epoch_cnt_q;
  logic                  wr_we_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rd_valid_q;
  logic                  rd_hit_q;
  logic                  err_overrun_q;
  logic                  err_range_q;

  logic                  start_take;
  logic                  accept;
  logic                  last_rec;
  logic                  serve_req;
  logic                  rd_hit;
  logic                  epoch_tick;
  logic [7:0]            epoch_next;
  logic [DATA_WIDTH-1:0] field_mask;

  assign start_take = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign accept     = (state_q == ST_LOAD) && bus.rec_valid;
  assign last_rec   = accept && ((load_cnt_q + ADDR_ONE) == num_dp_q);
  assign serve_req  = (state_q == ST_SERVE) && bus.rd_req;
  assign rd_hit     = serve_req && (bus.rd_addr < num_dp_q);
  assign epoch_tick = (state_q == ST_SERVE) && epoch_done;
  assign epoch_next = (epoch_cnt_q == 8'hFF) ? 8'hFF : epoch_cnt_q + 8'd1;

  // Valid fields sit at the top of the record; field i (0 = topmost) is kept
  // when i <= feat.
  always_comb begin
    field_mask = '0;
    for (int i = 0; i <= MAX_FEATURES; i++) begin
      if (i <= int'(feat_q)) begin
        field_mask[DATA_WIDTH-1-LENGTH*i -: LENGTH] = '1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = (num_dp == '0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD:  if (last_rec) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_SERVE;
      ST_SERVE: if (epoch_tick && (epoch_next == epochs_q)) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      num_dp_q      <= '0;
      feat_q        <= '0;
      epochs_q      <= '0;
      load_cnt_q    <= '0;
      epoch_cnt_q   <= '0;
      wr_we_q       <= 1'b0;
      wr_addr_q     <= '0;
      wdata_q       <= '0;
      rd_valid_q    <= 1'b0;
      rd_hit_q      <= 1'b0;
      err_overrun_q <= 1'b0;
      err_range_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_we_q    <= accept;
      wr_addr_q  <= load_cnt_q;
      rd_valid_q <= serve_req;
      rd_hit_q   <= rd_hit;
      if (accept) wdata_q <= bus.rec_data & field_mask;
      if (start_take) begin
        num_dp_q      <= num_dp;
        feat_q        <= feat;
        epochs_q      <= (epochs == 8'd0) ? 8'd1 : epochs;
        load_cnt_q    <= '0;
        epoch_cnt_q   <= '0;
        err_overrun_q <= 1'b0;
        err_range_q   <= 1'b0;
      end else begin
        if (accept) load_cnt_q <= load_cnt_q + ADDR_ONE;
        if (epoch_tick) epoch_cnt_q <= epoch_next;
        if (bus.rec_valid && state_q != ST_LOAD) err_overrun_q <= 1'b1;
        if (serve_req && !rd_hit) err_range_q <= 1'b1;
      end
    end
  end

  // Writes are registered and reads combinational; they live in disjoint
  // phases (the last write drains in FLUSH), so they never collide.
  assign bus.rec_ready = (state_q == ST_LOAD);
  assign bus.ram_we    = wr_we_q;
  assign bus.ram_re    = rd_hit;
  assign bus.ram_addr  = wr_we_q ? wr_addr_q : (rd_hit ? bus.rd_addr : '0);
  assign bus.ram_wdata = wdata_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_hit_q ? bus.ram_rdata : '0;

  assign epoch_cnt   = epoch_cnt_q;
  assign load_cnt    = load_cnt_q;
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_FLUSH) ||
                       (state_q == ST_SERVE);
  assign done        = (state_q == ST_DONE);
  assign err_overrun = err_overrun_q;
  assign err_range   = err_range_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_dataset_load_ctrl.sv
module tb_dataset_load_ctrl;
  localparam int AW = 12;
  localparam int DW = 256;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_SERVE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic          CLK;
  logic          RST;
  logic          start;
  logic [AW-1:0] num_dp;
  logic [3:0]    feat;
  logic [7:0]    epochs;
  logic          epoch_done;
  logic [7:0]    epoch_cnt;
  logic [AW-1:0] load_cnt;
  logic          busy;
  logic          done;
  logic          err_overrun;
  logic          err_range;
  logic [2:0]    dbg_state;

  int tests;
  int fails;

  logic [DW-1:0] exp_w [4];
  logic [DW-1:0] mem [16];

  dataset_load_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  dataset_load_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start), .num_dp(num_dp), .feat(feat),
    .epochs(epochs), .epoch_done(epoch_done), .epoch_cnt(epoch_cnt),
    .load_cnt(load_cnt), .busy(busy), .done(done),
    .err_overrun(err_overrun), .err_range(err_range),
    .dbg_state(dbg_state), .bus(bus_if)
  );

  // clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // dataset RAM model, 1-cycle synchronous read
  always @(posedge CLK) begin
    if (bus_if.ram_we) mem[bus_if.ram_addr[3:0]] <= bus_if.ram_wdata;
    if (bus_if.ram_re) bus_if.ram_rdata <= mem[bus_if.ram_addr[3:0]];
  end

  function automatic logic [DW-1:0] rec_of(input int i);
    logic [DW-1:0] r;
    r = '1;
    if (i != 0) r[DW-1 -: 32] = {16'hA000 + 16'(i), 16'hB000 + 16'(i)};
    return r;
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    tests++;
    if (dbg_state !== S_IDLE || busy !== 1'b0 || done !== 1'b0 ||
        load_cnt !== '0 || epoch_cnt !== '0 || err_overrun !== 1'b0 ||
        err_range !== 1'b0 || bus_if.rec_ready !== 1'b0 ||
        bus_if.ram_we !== 1'b0 || bus_if.ram_re !== 1'b0 ||
        bus_if.ram_addr !== '0 || bus_if.ram_wdata !== '0 ||
        bus_if.rd_valid !== 1'b0 || bus_if.rd_data !== '0) begin
      fails++;
      $display("FAIL reset_state: state=%0d busy=%b done=%b load_cnt=%0d we=%b re=%b rd_valid=%b, required all zero",
               dbg_state, busy, done, load_cnt, bus_if.ram_we, bus_if.ram_re, bus_if.rd_valid);
    end
  endtask

  task automatic test_load();
    start = 1'b1; num_dp = 12'd4; feat = 4'd1; epochs = 8'd2;
    @(negedge CLK);
    start = 1'b0;
    tests++;
    if (dbg_state !== S_LOAD || bus_if.rec_ready !== 1'b1 || busy !== 1'b1 || load_cnt !== '0) begin
      fails++;
      $display("FAIL load_enter: state=%0d rec_ready=%b busy=%b load_cnt=%0d, required 1/1/1/0",
               dbg_state, bus_if.rec_ready, busy, load_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      bus_if.rec_valid = 1'b1;
      bus_if.rec_data  = rec_of(i);
      @(negedge CLK);
      tests++;
      if (bus_if.ram_we !== 1'b1 || bus_if.ram_re !== 1'b0 ||
          bus_if.ram_addr !== AW'(i) || bus_if.ram_wdata !== exp_w[i] ||
          load_cnt !== AW'(i + 1)) begin
        fails++;
        $display("FAIL load_write%0d: we=%b re=%b addr=%0d load_cnt=%0d wdata=%h, required 1/0/%0d/%0d %h",
                 i, bus_if.ram_we, bus_if.ram_re, bus_if.ram_addr, load_cnt, bus_if.ram_wdata,
                 i, i + 1, exp_w[i]);
      end
    end
    bus_if.rec_valid = 1'b0;
    tests++;
    if (dbg_state !== S_FLUSH || bus_if.rec_ready !== 1'b0) begin
      fails++;
      $display("FAIL load_flush: state=%0d rec_ready=%b, required %0d/0", dbg_state, bus_if.rec_ready, S_FLUSH);
    end
    @(negedge CLK);
    tests++;
    if (dbg_state !== S_SERVE || bus_if.ram_we !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL load_serve: state=%0d we=%b busy=%b, required %0d/0/1", dbg_state, bus_if.ram_we, busy, S_SERVE);
    end
  endtask

  task automatic test_start_ignored();
    start = 1'b1; num_dp = 12'd0;
    @(negedge CLK);
    start = 1'b0;
    tests++;
    if (dbg_state !== S_SERVE || load_cnt !== 12'd4) begin
      fails++;
      $display("FAIL start_busy: state=%0d load_cnt=%0d, required %0d/4", dbg_state, load_cnt, S_SERVE);
    end
  endtask

  task automatic test_serve_reads();
    bus_if.rd_req = 1'b1; bus_if.rd_addr = 12'd2;
    #1;
    tests++;
    if (bus_if.ram_re !== 1'b1 || bus_if.ram_addr !== 12'd2 || bus_if.ram_we !== 1'b0) begin
      fails++;
      $display("FAIL read_issue2: re=%b addr=%0d we=%b, required 1/2/0", bus_if.ram_re, bus_if.ram_addr, bus_if.ram_we);
    end
    @(negedge CLK);
    tests++;
    if (bus_if.rd_valid !== 1'b1 || bus_if.rd_data !== exp_w[2]) begin
      fails++;
      $display("FAIL read_data2: valid=%b data=%h, required 1 %h", bus_if.rd_valid, bus_if.rd_data, exp_w[2]);
    end
    bus_if.rd_addr = 12'd3;
    #1;
    tests++;
    if (bus_if.ram_re !== 1'b1 || bus_if.ram_addr !== 12'd3) begin
      fails++;
      $display("FAIL read_issue3: re=%b addr=%0d, required 1/3", bus_if.ram_re, bus_if.ram_addr);
    end
    @(negedge CLK);
    bus_if.rd_req = 1'b0;
    #1;
    tests++;
    if (bus_if.rd_valid !== 1'b1 || bus_if.rd_data !== exp_w[3] ||
        bus_if.ram_re !== 1'b0 || bus_if.ram_addr !== '0) begin
      fails++;
      $display("FAIL read_data3: valid=%b re=%b addr=%0d data=%h, required 1/0/0 %h",
               bus_if.rd_valid, bus_if.ram_re, bus_if.ram_addr, bus_if.rd_data, exp_w[3]);
    end
  endtask

  task automatic test_range();
    @(negedge CLK);
    bus_if.rd_req = 1'b1; bus_if.rd_addr = 12'd4;
    #1;
    tests++;
    if (bus_if.ram_re !== 1'b0 || bus_if.ram_addr !== '0) begin
      fails++;
      $display("FAIL range_noaccess: re=%b addr=%0d, required 0/0", bus_if.ram_re, bus_if.ram_addr);
    end
    @(negedge CLK);
    bus_if.rd_req = 1'b0;
    tests++;
    if (bus_if.rd_valid !== 1'b1 || bus_if.rd_data !== '0 || err_range !== 1'b1) begin
      fails++;
      $display("FAIL range_resp: valid=%b data=%h err_range=%b, required 1/0/1", bus_if.rd_valid, bus_if.rd_data, err_range);
    end
    @(negedge CLK);
    tests++;
    if (err_range !== 1'b1 || bus_if.rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL range_sticky: err_range=%b valid=%b, required 1/0", err_range, bus_if.rd_valid);
    end
  endtask

  task automatic test_epochs();
    epoch_done = 1'b1;
    @(negedge CLK);
    epoch_done = 1'b0;
    tests++;
    if (epoch_cnt !== 8'd1 || done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL epoch_first: epoch_cnt=%0d done=%b busy=%b, required 1/0/1", epoch_cnt, done, busy);
    end
    epoch_done = 1'b1; bus_if.rd_req = 1'b1; bus_if.rd_addr = 12'd1;
    @(negedge CLK);
    epoch_done = 1'b0; bus_if.rd_req = 1'b0;
    tests++;
    if (epoch_cnt !== 8'd2 || done !== 1'b1 || busy !== 1'b0 || dbg_state !== S_DONE) begin
      fails++;
      $display("FAIL epoch_last: epoch_cnt=%0d done=%b busy=%b state=%0d, required 2/1/0/%0d",
               epoch_cnt, done, busy, dbg_state, S_DONE);
    end
    tests++;
    if (bus_if.rd_valid !== 1'b1 || bus_if.rd_data !== exp_w[1]) begin
      fails++;
      $display("FAIL epoch_last_read: valid=%b data=%h, required 1 %h", bus_if.rd_valid, bus_if.rd_data, exp_w[1]);
    end
    bus_if.rd_req = 1'b1; bus_if.rd_addr = 12'd0; epoch_done = 1'b1;
    #1;
    tests++;
    if (bus_if.ram_re !== 1'b0) begin
      fails++;
      $display("FAIL done_noread: re=%b, required 0", bus_if.ram_re);
    end
    @(negedge CLK);
    bus_if.rd_req = 1'b0; epoch_done = 1'b0;
    tests++;
    if (bus_if.rd_valid !== 1'b0 || epoch_cnt !== 8'd2 || done !== 1'b1) begin
      fails++;
      $display("FAIL done_hold: valid=%b epoch_cnt=%0d done=%b, required 0/2/1", bus_if.rd_valid, epoch_cnt, done);
    end
  endtask

  task automatic test_zero_dp();
    start = 1'b1; num_dp = 12'd0; feat = 4'd0; epochs = 8'd3;
    @(negedge CLK);
    start = 1'b0;
    tests++;
    if (dbg_state !== S_DONE || done !== 1'b1 || load_cnt !== '0 ||
        epoch_cnt !== '0 || err_range !== 1'b0 || bus_if.ram_we !== 1'b0) begin
      fails++;
      $display("FAIL zero_dp: state=%0d done=%b load_cnt=%0d epoch_cnt=%0d err_range=%b we=%b, required %0d/1/0/0/0/0",
               dbg_state, done, load_cnt, epoch_cnt, err_range, bus_if.ram_we, S_DONE);
    end
  endtask

  task automatic test_zero_epochs();
    logic [DW-1:0] exp1;
    exp1 = '0;
    exp1[DW-1 -: 16] = 16'hFFFF;
    start = 1'b1; num_dp = 12'd1; feat = 4'd0; epochs = 8'd0;
    @(negedge CLK);
    start = 1'b0;
    bus_if.rec_valid = 1'b1; bus_if.rec_data = '1;
    @(negedge CLK);
    bus_if.rec_valid = 1'b0;
    tests++;
    if (dbg_state !== S_FLUSH || bus_if.ram_wdata !== exp1 || bus_if.ram_addr !== '0 || load_cnt !== 12'd1) begin
      fails++;
      $display("FAIL feat0_write: state=%0d addr=%0d load_cnt=%0d wdata=%h, required %0d/0/1 %h",
               dbg_state, bus_if.ram_addr, load_cnt, bus_if.ram_wdata, S_FLUSH, exp1);
    end
    @(negedge CLK);
    epoch_done = 1'b1;
    @(negedge CLK);
    epoch_done = 1'b0;
    tests++;
    if (done !== 1'b1 || epoch_cnt !== 8'd1) begin
      fails++;
      $display("FAIL zero_epochs: done=%b epoch_cnt=%0d, required 1/1", done, epoch_cnt);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; num_dp = 12'd4; feat = 4'd3; epochs = 8'd1;
    @(negedge CLK);
    start = 1'b0;
    bus_if.rec_valid = 1'b1; bus_if.rec_data = rec_of(1);
    repeat (2) @(negedge CLK);
    bus_if.rec_valid = 1'b0;
    tests++;
    if (load_cnt !== 12'd2 || dbg_state !== S_LOAD) begin
      fails++;
      $display("FAIL mid_progress: load_cnt=%0d state=%0d, required 2/%0d", load_cnt, dbg_state, S_LOAD);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    tests++;
    if (dbg_state !== S_IDLE || load_cnt !== '0 || bus_if.rec_ready !== 1'b0 ||
        busy !== 1'b0 || bus_if.ram_we !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: state=%0d load_cnt=%0d rec_ready=%b busy=%b we=%b, required 0/0/0/0/0",
               dbg_state, load_cnt, bus_if.rec_ready, busy, bus_if.ram_we);
    end
    bus_if.rec_valid = 1'b1;
    @(negedge CLK);
    bus_if.rec_valid = 1'b0;
    tests++;
    if (err_overrun !== 1'b1 || bus_if.ram_we !== 1'b0 || load_cnt !== '0) begin
      fails++;
      $display("FAIL overrun: err_overrun=%b we=%b load_cnt=%0d, required 1/0/0", err_overrun, bus_if.ram_we, load_cnt);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    RST = 1'b1; start = 1'b0; num_dp = '0; feat = '0; epochs = '0; epoch_done = 1'b0;
    bus_if.rec_valid = 1'b0; bus_if.rec_data = '0;
    bus_if.rd_req = 1'b0; bus_if.rd_addr = '0;
    for (int i = 0; i < 4; i++) begin
      exp_w[i] = '0;
      exp_w[i][DW-1 -: 32] = (i == 0) ? 32'hFFFFFFFF : {16'hA000 + 16'(i), 16'hB000 + 16'(i)};
    end
    @(negedge CLK);
    test_reset();
    test_load();
    test_start_ignored();
    test_serve_reads();
    test_range();
    test_epochs();
    test_zero_dp();
    test_zero_epochs();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
